// File: rtl/ibex_cust_ctrl.sv
// Sequencer between EX and one shared multi-cycle custom unit (ALU_CUST0..4), with a one-entry
// result cache. Defining IBEX_CUST_TIMEOUT_EN adds the WAIT/DRAIN completion timeout.
module ibex_cust_ctrl #(
   parameter int unsigned TimeoutCycles = 32'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ex_req_i,
   input  logic [5:0]  ex_op_i,
   input  logic [31:0] ex_operand_a_i,
   input  logic [31:0] ex_operand_b_i,
   input  logic        ex_kill_i,
   output logic        ex_valid_o,
   output logic [31:0] ex_result_o,
   output logic        ex_err_o,
   output logic        busy_o,
   output logic        cu_start_o,
   output logic [2:0]  cu_op_o,
   output logic [31:0] cu_op_a_o,
   output logic [31:0] cu_op_b_o,
   input  logic        cu_done_i,
   input  logic [31:0] cu_result_i,
   output logic        cu_abort_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_ERR   = 3'd4,
      S_DRAIN = 3'd5
   } state_e;

   state_e      state_r, state_s;
   logic [2:0]  op_r;
   logic [31:0] op_a_r, op_b_r, result_r;
   logic        cache_valid_r;
   logic [2:0]  cache_op_r;
   logic [31:0] cache_a_r, cache_b_r, cache_res_r;

   logic        legal_s, hit_s, expired_s, abort_s;
   logic        latch_s, load_hit_s, cache_wr_s, cache_inv_s;
   logic [2:0]  op_idx_s;

   // Legal ops are 16..20, so the low three bits are already the unit op index.
   assign legal_s  = (ex_op_i >= 6'd16) && (ex_op_i <= 6'd20);
   assign op_idx_s = ex_op_i[2:0];
   assign hit_s    = cache_valid_r && (cache_op_r == op_idx_s) &&
                     (cache_a_r == ex_operand_a_i) && (cache_b_r == ex_operand_b_i);

`ifdef IBEX_CUST_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 32'd1);
   logic [CntW-1:0] cnt_r;

   assign expired_s = (cnt_r == CntW'(TimeoutCycles));

   // Cycles spent in the current WAIT/DRAIN visit; any state change restarts from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_r <= '0;
      end else if (((state_r == S_WAIT) || (state_r == S_DRAIN)) && (state_s == state_r)) begin
         cnt_r <= cnt_r + CntW'(1);
      end else begin
         cnt_r <= '0;
      end
   end
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^TimeoutCycles;
   assign expired_s        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, datapath strobes and EX/unit handshake outputs.
   always_comb begin
      state_s     = state_r;
      latch_s     = 1'b0;
      load_hit_s  = 1'b0;
      cache_wr_s  = 1'b0;
      cache_inv_s = 1'b0;
      abort_s     = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (ex_req_i && !ex_kill_i) begin
               if (!legal_s) begin
                  state_s = S_ERR;
               end else if (hit_s) begin
                  state_s    = S_RESP;
                  load_hit_s = 1'b1;
               end else begin
                  state_s = S_ISSUE;
                  latch_s = 1'b1;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (ex_kill_i) begin
               state_s = S_DRAIN;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_WAIT: begin
            // Completion wins over both kill and timeout; a killed completion still fills the cache.
            if (cu_done_i) begin
               cache_wr_s = 1'b1;
               state_s    = ex_kill_i ? S_IDLE : S_RESP;
            end else if (expired_s) begin
               abort_s     = 1'b1;
               cache_inv_s = 1'b1;
               state_s     = ex_kill_i ? S_IDLE : S_ERR;
            end else if (ex_kill_i) begin
               state_s = S_DRAIN;
            end else begin
               state_s = S_WAIT;
            end
         end
         S_RESP:  state_s = S_IDLE;
         S_ERR:   state_s = S_IDLE;
         S_DRAIN: begin
            if (cu_done_i) begin
               state_s = S_IDLE;
            end else if (expired_s) begin
               abort_s = 1'b1;
               state_s = S_IDLE;
            end else begin
               state_s = S_DRAIN;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Strobes are held off during the reset cycle itself.
   always_comb begin
      ex_valid_o  = 1'b0;
      ex_err_o    = 1'b0;
      ex_result_o = 32'h0000_0000;
      if (!rst_i && !ex_kill_i && (state_r == S_RESP)) begin
         ex_valid_o  = 1'b1;
         ex_result_o = result_r;
      end else if (!rst_i && !ex_kill_i && (state_r == S_ERR)) begin
         ex_valid_o = 1'b1;
         ex_err_o   = 1'b1;
      end else begin
         ex_valid_o  = 1'b0;
         ex_err_o    = 1'b0;
         ex_result_o = 32'h0000_0000;
      end
   end

   assign busy_o     = (state_r != S_IDLE);
   assign cu_start_o = !rst_i && (state_r == S_ISSUE);
   assign cu_abort_o = !rst_i && abort_s;
   assign cu_op_o    = op_r;
   assign cu_op_a_o  = op_a_r;
   assign cu_op_b_o  = op_b_r;

   // Issue operands, result register and the one-entry cache.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_r          <= 3'd0;
         op_a_r        <= 32'h0000_0000;
         op_b_r        <= 32'h0000_0000;
         result_r      <= 32'h0000_0000;
         cache_valid_r <= 1'b0;
         cache_op_r    <= 3'd0;
         cache_a_r     <= 32'h0000_0000;
         cache_b_r     <= 32'h0000_0000;
         cache_res_r   <= 32'h0000_0000;
      end else begin
         if (latch_s) begin
            op_r   <= op_idx_s;
            op_a_r <= ex_operand_a_i;
            op_b_r <= ex_operand_b_i;
         end
         if (cache_wr_s) begin
            result_r      <= cu_result_i;
            cache_res_r   <= cu_result_i;
            cache_op_r    <= op_r;
            cache_a_r     <= op_a_r;
            cache_b_r     <= op_b_r;
            cache_valid_r <= 1'b1;
         end else if (load_hit_s) begin
            result_r <= cache_res_r;
         end else if (cache_inv_s) begin
            cache_valid_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ibex_cust_ctrl.sv
// Scoreboarded bench for ibex_cust_ctrl: a driver issues ops and plays the custom unit while a
// monitor matches every EX response against expectations from a cache-level reference model.
module tb_ibex_cust_ctrl;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst, ex_req, ex_kill, cu_done;
   logic [5:0]  ex_op;
   logic [31:0] ex_a, ex_b, cu_res;
   logic        ex_valid, ex_err, busy, cu_start, cu_abort;
   logic [31:0] ex_result, cu_op_a, cu_op_b;
   logic [2:0]  cu_op;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        err;
      logic [31:0] res;
      int          at;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: one cached (op, a, b) -> result entry
   bit          m_valid = 1'b0;
   logic [5:0]  m_op;
   logic [31:0] m_a, m_b, m_res;

   logic [5:0]  ill [4];

   ibex_cust_ctrl #(.TimeoutCycles(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ex_req_i       (ex_req),
      .ex_op_i        (ex_op),
      .ex_operand_a_i (ex_a),
      .ex_operand_b_i (ex_b),
      .ex_kill_i      (ex_kill),
      .ex_valid_o     (ex_valid),
      .ex_result_o    (ex_result),
      .ex_err_o       (ex_err),
      .busy_o         (busy),
      .cu_start_o     (cu_start),
      .cu_op_o        (cu_op),
      .cu_op_a_o      (cu_op_a),
      .cu_op_b_o      (cu_op_b),
      .cu_done_i      (cu_done),
      .cu_result_i    (cu_res),
      .cu_abort_o     (cu_abort)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h cycle=%0d", name, got, want, cyc);
      end
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_ex_valid"},  32'(ex_valid),  32'd0);
      chk({tag, "_ex_result"}, ex_result,      32'd0);
      chk({tag, "_ex_err"},    32'(ex_err),    32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_cu_start"},  32'(cu_start),  32'd0);
      chk({tag, "_cu_op"},     32'(cu_op),     32'd0);
      chk({tag, "_cu_op_a"},   cu_op_a,        32'd0);
      chk({tag, "_cu_op_b"},   cu_op_b,        32'd0);
      chk({tag, "_cu_abort"},  32'(cu_abort),  32'd0);
   endtask

   // Monitor: every EX response must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (ex_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_response cycle=%0d err=%b result=%h", cyc, ex_err, ex_result);
         end else begin
            mon_e = exp_q.pop_front();
            if (ex_err !== mon_e.err || ex_result !== mon_e.res || cyc != mon_e.at) begin
               errors++;
               $display("FAIL response cycle=%0d err=%b result=%h want cycle=%0d err=%b result=%h",
                        cyc, ex_err, ex_result, mon_e.at, mon_e.err, mon_e.res);
            end
         end
      end
   end

   task automatic idle(input int k);
      for (int t = 0; t < k; t++) begin
         @(posedge clk); #1;
         ex_req  = 1'b0;
         ex_kill = 1'b0;
         cu_done = ($urandom_range(0, 3) == 0);   // stray done in IDLE must be ignored
         cu_res  = $urandom;
      end
   endtask

   // One request held until its response; the driver also plays the unit with latency lat.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] res);
      int   n, start_at;
      bit   legal, hit, started, got_valid;
      exp_t x;
      legal     = (op >= 6'd16) && (op <= 6'd20);
      hit       = legal && m_valid && (m_op == op) && (m_a == a) && (m_b == b);
      started   = 1'b0;
      got_valid = 1'b0;
      start_at  = 0;
      n         = 0;
      for (int t = 0; t < 64 && !got_valid; t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            n = cyc;
            if (!legal) begin
               x.err = 1'b1; x.res = 32'd0; x.at = n + 1;
            end else if (hit) begin
               x.err = 1'b0; x.res = m_res; x.at = n + 1;
            end else begin
               x.err = 1'b0; x.res = res; x.at = n + 2 + lat;
               m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_res = res;
            end
            exp_q.push_back(x);
         end
         ex_req  = 1'b1;
         ex_op   = op;
         ex_a    = a;
         ex_b    = b;
         ex_kill = 1'b0;
         cu_done = started && (cyc == start_at + lat);
         cu_res  = cu_done ? res : $urandom;
         @(negedge clk);
         if (t == 0) chk("idle_at_accept", 32'(busy), 32'd0);
         if (cu_start === 1'b1) begin
            if (started || !legal || hit || cyc != n + 1) begin
               chk("unexpected_start_cycle", 32'(cyc), 32'(n + 1));
               if (cyc == n + 1) chk("unexpected_start", 32'd1, 32'd0);
            end else begin
               started  = 1'b1;
               start_at = cyc;
               chk("cu_op", 32'(cu_op), 32'(op - 6'd16));
               chk("cu_op_a", cu_op_a, a);
               chk("cu_op_b", cu_op_b, b);
            end
         end
         if (cu_done) chk("cu_op_b_stable", cu_op_b, b);
         if (ex_valid === 1'b1) got_valid = 1'b1;
      end
      chk("response_seen", 32'(got_valid), 32'd1);
   endtask

   // Miss request killed at offset kill_off; unit completes at offset done_off.
   task automatic kill_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int kill_off, input int done_off, input logic [31:0] res);
      int nstart = 0;
      for (int t = 0; t <= done_off; t++) begin
         @(posedge clk); #1;
         ex_req  = 1'b1;
         ex_op   = op;
         ex_a    = a;
         ex_b    = b;
         ex_kill = (t == kill_off);
         cu_done = (t == done_off);
         cu_res  = cu_done ? res : $urandom;
         @(negedge clk);
         if (cu_start === 1'b1) begin
            nstart++;
            chk("kill_start_offset", 32'(t), 32'd1);
         end
         if (t == done_off) chk("busy_at_done", 32'(busy), 32'd1);
      end
      chk("kill_start_count", 32'(nstart), 32'd1);
      if (kill_off >= 2 && done_off == kill_off) begin
         m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_res = res;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cycle_valid", 32'(ex_valid), 32'd0);
      chk("rst_cycle_start", 32'(cu_start), 32'd0);
      chk("rst_cycle_abort", 32'(cu_abort), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; ex_req = 1'b0; ex_kill = 1'b0; cu_done = 1'b0;
      @(negedge clk);
      zero_check("after_reset");
      m_valid = 1'b0;
   endtask

   task automatic reset_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      for (int t = 0; t < 3; t++) begin
         @(posedge clk); #1;
         ex_req = 1'b1; ex_op = op; ex_a = a; ex_b = b; ex_kill = 1'b0; cu_done = 1'b0;
         @(negedge clk);
         if (t == 1) chk("reset_txn_start", 32'(cu_start), 32'd1);
      end
      do_reset();
   endtask

`ifdef IBEX_CUST_TIMEOUT_EN
   task automatic timeout_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      int   nab = 0;
      exp_t x;
      for (int t = 0; t <= int'(TO) + 3; t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            x.err = 1'b1; x.res = 32'd0; x.at = cyc + int'(TO) + 3;
            exp_q.push_back(x);
         end
         ex_req = 1'b1; ex_op = op; ex_a = a; ex_b = b; ex_kill = 1'b0;
         cu_done = 1'b0; cu_res = $urandom;
         @(negedge clk);
         if (cu_abort === 1'b1) begin
            nab++;
            chk("abort_offset", 32'(t), 32'(TO + 2));
         end
      end
      chk("abort_count", 32'(nab), 32'd1);
      m_valid = 1'b0;
   endtask
`else
   task automatic hang_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      int bad = 0;
      for (int t = 0; t < 1002; t++) begin
         @(posedge clk); #1;
         ex_req = 1'b1; ex_op = op; ex_a = a; ex_b = b; ex_kill = 1'b0; cu_done = 1'b0;
         @(negedge clk);
         if (t >= 1 && (busy !== 1'b1 || ex_valid !== 1'b0 || cu_abort !== 1'b0)) bad++;
      end
      chk("hang_no_output", 32'(bad), 32'd0);
      do_reset();
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          r, ko, dof;
      logic [5:0]  op;
      logic [31:0] a, b;
      ill = '{6'd0, 6'd15, 6'd21, 6'd63};
      rst = 1'b1; ex_req = 1'b0; ex_kill = 1'b0; cu_done = 1'b0;
      ex_op = 6'd0; ex_a = 32'd0; ex_b = 32'd0; cu_res = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      zero_check("reset");

      run_txn(6'd18, 32'h1234, 32'h5678, 3, 32'hCAFE_0001);
      idle(2);
      run_txn(6'd18, 32'h1234, 32'h5678, 3, 32'hDEAD_0000);
      run_txn(6'd18, 32'h1234, 32'h5679, 2, 32'h0BAD_F00D);
      run_txn(6'd0, 32'h1, 32'h2, 1, 32'h0);
      kill_txn(6'd17, 32'hA5A5_0001, 32'h3C3C_0002, 3, 7, 32'h1111_2222);
      run_txn(6'd17, 32'hA5A5_0001, 32'h3C3C_0002, 2, 32'h2222_3333);
      kill_txn(6'd19, 32'h0000_0BEE, 32'h0000_0CAF, 2, 2, 32'h4444_5555);
      run_txn(6'd19, 32'h0000_0BEE, 32'h0000_0CAF, 1, 32'h6666_7777);
      idle(1);

`ifdef IBEX_CUST_TIMEOUT_EN
      run_txn(6'd16, 32'd7, 32'd8, 1, 32'h7777_0001);
      timeout_txn(6'd20, 32'd9, 32'd10);
      run_txn(6'd16, 32'd7, 32'd8, 2, 32'h7777_0002);
`else
      hang_txn(6'd20, 32'd9, 32'd10);
      run_txn(6'd16, 32'd7, 32'd8, 2, 32'h7777_0002);
`endif
      reset_txn(6'd17, 32'd100, 32'd200);
      run_txn(6'd16, 32'd7, 32'd8, 4, 32'h7777_0003);

      for (int i = 0; i < 80; i++) begin
         r  = $urandom_range(0, 9);
         a  = ($urandom_range(0, 1) == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
         b  = ($urandom_range(0, 1) == 0) ? 32'h0000_0000 : 32'h8000_0000;
         op = 6'(32'd16 + $urandom_range(0, 4));
         if (r == 0) op = ill[$urandom_range(0, 3)];
         if (r == 1) begin
            a   = $urandom | 32'h0001_0000;
            ko  = $urandom_range(1, 3);
            dof = ((ko < 2) ? 2 : ko) + $urandom_range(0, 3);
            kill_txn(op, a, b, ko, dof, $urandom);
            run_txn(op, a, b, $urandom_range(1, 4), $urandom);
         end else begin
            run_txn(op, a, b, $urandom_range(1, 4), $urandom);
         end
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
